// File: rtl/jedro_1_dmem_resp_pkg.sv
// Shared constants and FSM encoding for the jedro_1 data-memory responder.
// Defaults match the core's 32-bit data interface.
package jedro_1_dmem_resp_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;
    localparam int CNT_WIDTH      = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/jedro_1_dmem_resp_if.sv
// Core data interface: req/gnt handshake with one-cycle rvalid response.
// The master holds req and the request fields stable until the gnt cycle.
interface jedro_1_dmem_resp_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  req;
    logic                  gnt;
    logic                  rvalid;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/jedro_1_sram_be.sv
// Single-port synchronous RAM with per-byte write enables; read data registered
// at the enabled edge. No flow control: every enabled cycle is serviced.
module jedro_1_sram_be #(
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    localparam int AW             = $clog2(MEM_DEPTH_WORDS),
    localparam int BE_W           = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [BE_W-1:0]       be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/jedro_1_dmem_resp.sv
// Data-memory responder: grants after WAIT_CYCLES, response one cycle after grant.
// Backpressure is the grant itself; the initiator holds its request until gnt.
module jedro_1_dmem_resp
    import jedro_1_dmem_resp_pkg::*;
#(
    parameter int          DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int          MEM_DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          WAIT_CYCLES     = 0
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    jedro_1_dmem_resp_if.slave bus
);

    localparam int AW = $clog2(MEM_DEPTH_WORDS);

    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   gnt;
    logic [31:0]            offset;
    logic                   legal;
    logic                   rvalid_q;
    logic                   err_q;
    logic                   rd_q;
    logic [DATA_WIDTH-1:0]  ram_rdata;

    assign gnt = rstn_i & bus.req & (cnt_q == CNT_WIDTH'(WAIT_CYCLES));

    // BASE_ADDR is word aligned, so the offset's low bits carry the alignment.
    assign offset = bus.addr - BASE_ADDR;
    assign legal  = (bus.addr >= BASE_ADDR)
                  & (offset[31:AW+2] == '0)
                  & (offset[1:0] == 2'b00)
                  & (|bus.be);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  if (bus.req && (WAIT_CYCLES != 0)) state_d = STALL;
            STALL: if (gnt || !bus.req)               state_d = IDLE;
            default:                                  state_d = IDLE;
        endcase
        if (!bus.req || gnt) cnt_d = '0;
        else                 cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt;
            err_q    <= gnt & ~legal;
            rd_q     <= gnt & legal & ~bus.we;
        end
    end

    jedro_1_sram_be #(
        .DATA_WIDTH      (DATA_WIDTH),
        .MEM_DEPTH_WORDS (MEM_DEPTH_WORDS)
    ) u_sram (
        .clk   (clk_i),
        .en    (gnt & legal),
        .we    (bus.we),
        .be    (bus.be),
        .addr  (offset[AW+1:2]),
        .wdata (bus.wdata),
        .rdata (ram_rdata)
    );

    // RAM output is only exposed in the response cycle of a legal read.
    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rd_q ? ram_rdata : '0;

endmodule

// File: tb/tb_jedro_1_dmem_resp.sv
// Scoreboarded bench: three responders (0, 2 and 3 wait cycles) driven one at a time.
module tb_jedro_1_dmem_resp;

    localparam logic [31:0] BASES [3] = '{32'h0000_0000, 32'h0000_2000, 32'h0000_0000};
    localparam int          WAITS [3] = '{0, 2, 3};

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        req;
    int          sel;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;

    jedro_1_dmem_resp_if bus0 ();
    jedro_1_dmem_resp_if bus1 ();
    jedro_1_dmem_resp_if bus2 ();

    assign bus0.req = req && (sel == 0);
    assign bus1.req = req && (sel == 1);
    assign bus2.req = req && (sel == 2);
    assign bus0.we = we;    assign bus1.we = we;    assign bus2.we = we;
    assign bus0.be = be;    assign bus1.be = be;    assign bus2.be = be;
    assign bus0.addr = addr;  assign bus1.addr = addr;  assign bus2.addr = addr;
    assign bus0.wdata = wdata; assign bus1.wdata = wdata; assign bus2.wdata = wdata;

    jedro_1_dmem_resp #(.WAIT_CYCLES(0)) u_w0 (.clk_i(clk), .rstn_i(rstn), .bus(bus0));
    jedro_1_dmem_resp #(.WAIT_CYCLES(2), .BASE_ADDR(32'h0000_2000))
                                         u_w2 (.clk_i(clk), .rstn_i(rstn), .bus(bus1));
    jedro_1_dmem_resp #(.WAIT_CYCLES(3)) u_w3 (.clk_i(clk), .rstn_i(rstn), .bus(bus2));

    logic        gn [3];
    logic        rv [3];
    logic        er [3];
    logic [31:0] rd [3];
    assign gn[0] = bus0.gnt;   assign gn[1] = bus1.gnt;   assign gn[2] = bus2.gnt;
    assign rv[0] = bus0.rvalid; assign rv[1] = bus1.rvalid; assign rv[2] = bus2.rvalid;
    assign er[0] = bus0.err;   assign er[1] = bus1.err;   assign er[2] = bus2.err;
    assign rd[0] = bus0.rdata; assign rd[1] = bus1.rdata; assign rd[2] = bus2.rdata;

    typedef struct {
        int          d;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        bit          chk;
    } exp_t;

    exp_t        expq [$];
    exp_t        mon_e;
    logic [31:0] mdl   [3][1024];
    bit          known [3][1024];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rv[d] === 1'b1) begin
                if (expq.size() == 0 || expq[0].d != d) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rvalid dut%0d: got rvalid 1, required 0 (cycle %0d)", d, cyc);
                end else begin
                    mon_e = expq.pop_front();
                    check("rvalid_cycle", cyc, mon_e.cyc);
                    check("resp_err", er[d], mon_e.err);
                    if (mon_e.chk) check("resp_rdata", rd[d], mon_e.rdata);
                end
            end else begin
                check("idle_rdata", rd[d], 32'h0);
                check("idle_err", er[d], 32'h0);
            end
        end
    end

    task automatic do_access(input int d, input bit w, input logic [3:0] b,
                             input logic [31:0] a, input logic [31:0] wd);
        int   waited;
        int   idx;
        bit   legal;
        exp_t e;
        waited = 0;
        @(posedge clk); #1;
        sel = d; we = w; be = b; addr = a; wdata = wd; req = 1'b1;
        forever begin
            @(negedge clk);
            if (gn[d] === 1'b1) break;
            waited++;
            if (waited > 50) break;
        end
        check("gnt_latency", 32'(waited), 32'(WAITS[d]));
        if (waited > 50) begin
            req = 1'b0;
            return;
        end
        legal = (a >= BASES[d]) && ((a - BASES[d]) < 32'd4096) && (a[1:0] == 2'b00) && (b != 4'h0);
        e.d = d; e.cyc = cyc + 1; e.rdata = 32'h0; e.err = !legal; e.chk = 1'b1;
        if (legal) begin
            idx = int'((a - BASES[d]) >> 2);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
                if (b == 4'hF) known[d][idx] = 1'b1;
            end else begin
                e.rdata = mdl[d][idx];
                e.chk   = known[d][idx];
            end
        end
        expq.push_back(e);
    endtask

    task automatic drop_access(input int d, input int k);
        @(posedge clk); #1;
        sel = d; we = 1'b1; be = 4'hF; addr = BASES[d] + 32'h20; wdata = $urandom; req = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("drop_no_gnt", gn[d], 32'h0);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    int          rd_d, rd_cat, rd_k;
    logic [31:0] rd_off;
    logic [3:0]  rd_be;

    initial begin
        req = 1'b0; sel = 0; we = 1'b0; be = 4'hF; addr = 32'h10; wdata = 32'h0;
        rstn = 1'b0;
        #1 req = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            check("reset_gnt", gn[d], 32'h0);
            check("reset_rvalid", rv[d], 32'h0);
            check("reset_err", er[d], 32'h0);
            check("reset_rdata", rd[d], 32'h0);
        end
        req = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;

        do_access(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        do_access(0, 1'b0, 4'hF, 32'h10, 32'h0);
        idle(2);
        do_access(0, 1'b1, 4'b0010, 32'h10, 32'h0000_AA00);
        idle(1);
        do_access(0, 1'b0, 4'h1, 32'h10, 32'h0);
        idle(1);
        do_access(0, 1'b0, 4'hF, 32'd4096, 32'h0);
        do_access(0, 1'b1, 4'hF, 32'h12, 32'h1111_1111);
        do_access(0, 1'b1, 4'h0, 32'h10, 32'h2222_2222);
        do_access(0, 1'b0, 4'hF, 32'h10, 32'h0);
        idle(2);
        for (int i = 0; i < 4; i++) do_access(0, 1'b1, 4'hF, 32'(4 * i), 32'(i + 1));
        idle(2);
        for (int i = 0; i < 4; i++) do_access(0, 1'b0, 4'hF, 32'(4 * i), 32'h0);
        idle(2);

        do_access(1, 1'b1, 4'hF, 32'h2010, 32'hCAFE_F00D);
        idle(1);
        drop_access(1, 1);
        idle(3);
        do_access(1, 1'b0, 4'hF, 32'h2010, 32'h0);
        do_access(1, 1'b0, 4'hF, 32'h1FFC, 32'h0);
        do_access(1, 1'b0, 4'hF, 32'h2FFC, 32'h0);
        idle(2);
        do_access(2, 1'b1, 4'hF, 32'h40, 32'h1234_5678);
        idle(2);

        // Reset with a response pending on the zero-wait responder.
        @(posedge clk); #1;
        sel = 0; we = 1'b0; be = 4'hF; addr = 32'h10; req = 1'b1;
        @(negedge clk);
        check("rst_pending_gnt", gn[0], 32'h1);
        @(posedge clk); #1;
        req = 1'b0;
        check("rst_pending_rvalid", rv[0], 32'h1);
        rstn = 1'b0;
        #1;
        check("rst_async_rvalid", rv[0], 32'h0);
        check("rst_async_rdata", rd[0], 32'h0);
        check("rst_async_err", er[0], 32'h0);
        @(negedge clk);
        @(posedge clk); #1 rstn = 1'b1;

        // Reset while the three-wait responder is stalling and granting.
        @(posedge clk); #1;
        sel = 2; we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'h0BAD_0BAD; req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_gnt", gn[2], 32'h0);
        end
        @(negedge clk);
        check("stall_gnt", gn[2], 32'h1);
        #1 rstn = 1'b0;
        #1;
        check("rst_stall_gnt", gn[2], 32'h0);
        check("rst_stall_rvalid", rv[2], 32'h0);
        req = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        repeat (4) @(negedge clk);
        do_access(2, 1'b0, 4'hF, 32'h40, 32'h0);
        idle(1);

        for (int n = 0; n < 300; n++) begin
            rd_d   = $urandom_range(0, 2);
            rd_cat = $urandom_range(0, 15);
            case (rd_cat)
                10:      rd_off = 32'd4092;
                11:      rd_off = 32'd4096 + 32'($urandom_range(0, 3) * 4);
                12:      rd_off = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                13:      rd_off = 32'hFFFF_FFF0;
                default: rd_off = 32'($urandom_range(0, 15) * 4);
            endcase
            rd_be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (rd_d > 0 && $urandom_range(0, 9) == 0) begin
                rd_k = $urandom_range(1, WAITS[rd_d] - 1);
                drop_access(rd_d, rd_k);
            end else begin
                do_access(rd_d, 1'($urandom_range(0, 1)), rd_be, BASES[rd_d] + rd_off, $urandom);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        check("queue_empty", 32'(expq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
